rr_arb2: RTL and testbench

Two-input round-robin arbiter and output register feeding the `multiplexor` select path. It accepts two valid/ready streams, decides each cycle which source is served, and drives `sel` to the 2:1 `multiplexor`. It registers the selected word into a single-entry output stage with valid/ready toward the consumer. This block sits directly upstream of, and wraps, the existing `multiplexor` datapath.

---
 rtl/rr_arb2_pkg.sv | 15 +
 rtl/multiplexor.sv | 23 ++
 rtl/rr_arb2.sv | 117 +++++++++++
 tb/tb_rr_arb2.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb2_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb2_pkg
// Shared constants for the two-input round-robin arbiter.
//   ST_EMPTY / ST_FULL : encoding of the single-entry output stage
//   LAST_RST           : value the "last served" pointer takes on reset;
//                        1 means source 0 wins the first contention.
// ----------------------------------------------------------------------------
package rr_arb2_pkg;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    localparam logic LAST_RST = 1'b1;

endpackage : rr_arb2_pkg

// File: rtl/multiplexor.sv
// ----------------------------------------------------------------------------
// multiplexor
// Existing 2:1 datapath select used by rr_arb2.
// Parameters:
//   WIDTH   : data width
// Ports:
//   sel     in  1      0 selects in0, 1 selects in1
//   in0     in  WIDTH  first input word
//   in1     in  WIDTH  second input word
//   mux_out out WIDTH  selected word
// ----------------------------------------------------------------------------
module multiplexor #(
    parameter int WIDTH = 5
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] mux_out
);

    assign mux_out = sel ? in1 : in0;

endmodule : multiplexor

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-input arbiter with a single-entry registered output stage. Each cycle
// it picks which valid/ready source is served, steers the multiplexor with
// sel, and captures the selected word into the output register.
//
// Configuration macro:
//   RR_ARB2_ROUND_ROBIN_EN  defined   : round-robin on contention
//                           undefined : fixed priority, source 0 wins
//
// Parameters:
//   WIDTH      : data width of both inputs and the output
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      synchronous active-high reset
//   in0_valid  in  1      source 0 holds a word
//   in0_data   in  WIDTH  source 0 word
//   in0_ready  out 1      source 0 word consumed this cycle
//   in1_valid  in  1      source 1 holds a word
//   in1_data   in  WIDTH  source 1 word
//   in1_ready  out 1      source 1 word consumed this cycle
//   sel        out 1      combinational grant / multiplexor select
//   out_valid  out 1      output register holds a word
//   out_data   out WIDTH  registered selected word
//   out_src    out 1      source index of out_data
//   out_ready  in  1      consumer takes out_data this cycle
// ----------------------------------------------------------------------------
module rr_arb2
    import rr_arb2_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    logic             state;
    logic             load;
    logic [WIDTH-1:0] mux_out;

`ifdef RR_ARB2_ROUND_ROBIN_EN
    logic last;

    // On contention the source that was not served last wins; with no
    // requester the select rests on the last served source.
    always_comb begin
        sel = last;
        if (in0_valid && in1_valid) begin
            sel = ~last;
        end else if (in0_valid) begin
            sel = 1'b0;
        end else if (in1_valid) begin
            sel = 1'b1;
        end
    end

    // Pointer to the most recently served source.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= LAST_RST;
        end else if (load) begin
            last <= sel;
        end
    end
`else
    // Fixed priority: source 1 is selected only when it requests alone.
    always_comb begin
        sel = in1_valid && !in0_valid;
    end
`endif

    // A word can be taken whenever the output register is empty or is being
    // drained in the same cycle; reset suppresses every handshake.
    assign load = ((state == ST_EMPTY) || ((state == ST_FULL) && out_ready))
                  && (in0_valid || in1_valid) && !rst;

    assign in0_ready = load && (sel == 1'b0);
    assign in1_ready = load && (sel == 1'b1);
    assign out_valid = (state == ST_FULL);

    multiplexor #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel     (sel),
        .in0     (in0_data),
        .in1     (in1_data),
        .mux_out (mux_out)
    );

    // Output stage. A simultaneous drain and load simply overwrites the
    // register and stays FULL; a drain alone leaves data/src untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_src  <= 1'b0;
        end else if (load) begin
            state    <= ST_FULL;
            out_data <= mux_out;
            out_src  <= sel;
        end else if ((state == ST_FULL) && out_ready) begin
            state    <= ST_EMPTY;
        end
    end

endmodule : rr_arb2

// File: tb/tb_rr_arb2.sv
// ----------------------------------------------------------------------------
// tb_rr_arb2
// Self-checking bench for rr_arb2 (WIDTH = 5). A behavioural reference keeps
// the output stage as a "holding a word" flag plus a queue of accepted words,
// and derives grants from the arbitration rules. Build with or without
// RR_ARB2_ROUND_ROBIN_EN; the reference follows the same macro.
// ----------------------------------------------------------------------------
module tb_rr_arb2;

    localparam int WIDTH = 5;

`ifdef RR_ARB2_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    always #5 clk = ~clk;

    rr_arb2 #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    int check_count = 0;
    int pass_count  = 0;

    // Reference state: is a word held, which word/source, who was served last
    bit               m_holding;
    logic [WIDTH-1:0] m_word;
    bit               m_src;
    int               m_last_served;
    logic [WIDTH-1:0] accepted_words[$];
    bit               exp_ready0;
    bit               exp_ready1;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, required %0h", tag, observed, expected);
        end
    endtask

    // Grant chosen by the arbitration rules for the given requests.
    function automatic bit refGrant(input bit v0, input bit v1);
        if (v0 && v1) return ROUND_ROBIN ? (m_last_served == 0) : 1'b0;
        if (v0) return 1'b0;
        if (v1) return 1'b1;
        return ROUND_ROBIN ? (m_last_served == 1) : 1'b0;
    endfunction

    // Drive one cycle of inputs, check the combinational outputs before the
    // edge, advance the reference across the edge, then check the register.
    task automatic applyStimulus(input bit r, input bit v0, input logic [WIDTH-1:0] d0,
                                 input bit v1, input logic [WIDTH-1:0] d1,
                                 input bit ordy);
        bit exp_sel;
        bit accept;
        @(negedge clk);
        rst       = r;
        in0_valid = v0;
        in0_data  = d0;
        in1_valid = v1;
        in1_data  = d1;
        out_ready = ordy;
        #1;
        exp_sel    = refGrant(v0, v1);
        accept     = (!m_holding || ordy) && (v0 || v1) && !r;
        exp_ready0 = accept && !exp_sel;
        exp_ready1 = accept && exp_sel;
        checkOutput("sel", {31'b0, sel}, {31'b0, exp_sel});
        checkOutput("in0_ready", {31'b0, in0_ready}, {31'b0, exp_ready0});
        checkOutput("in1_ready", {31'b0, in1_ready}, {31'b0, exp_ready1});
        if (!r && m_holding && ordy) begin
            if (accepted_words.size() > 0) begin
                checkOutput("drained_word", {27'b0, out_data}, {27'b0, accepted_words.pop_front()});
            end else begin
                checkOutput("drain_without_word", accepted_words.size(), 1);
            end
        end
        @(posedge clk);
        if (r) begin
            m_holding     = 1'b0;
            m_word        = '0;
            m_src         = 1'b0;
            m_last_served = 1;
            accepted_words.delete();
        end else if (accept) begin
            m_holding     = 1'b1;
            m_word        = exp_sel ? d1 : d0;
            m_src         = exp_sel;
            m_last_served = exp_sel ? 1 : 0;
            accepted_words.push_back(m_word);
        end else if (m_holding && ordy) begin
            m_holding = 1'b0;
        end
        #1;
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, m_holding});
        checkOutput("out_data", {27'b0, out_data}, {27'b0, m_word});
        checkOutput("out_src", {31'b0, out_src}, {31'b0, m_src});
    endtask

    initial begin
        bit               p0, p1;
        logic [WIDTH-1:0] w0, w1;
        int               grants0;

        m_holding     = 1'b0;
        m_word        = '0;
        m_src         = 1'b0;
        m_last_served = 1;

        // Bring the DUT out of its unknown power-up state before checking.
        rst       = 1'b1;
        in0_valid = 1'b0;
        in0_data  = '0;
        in1_valid = 1'b0;
        in1_data  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with idle and with requesting sources: no handshakes.
        applyStimulus(1, 0, 5'h00, 0, 5'h00, 0);
        applyStimulus(1, 1, 5'h15, 1, 5'h0A, 1);

        // Single request from source 0.
        applyStimulus(0, 1, 5'h15, 0, 5'h00, 1);
        checkOutput("single_in0_data", {27'b0, out_data}, 32'h15);
        applyStimulus(0, 0, 5'h00, 0, 5'h00, 1);

        // Continuous contention straight after reset.
        applyStimulus(1, 0, 5'h00, 0, 5'h00, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 5'h15, 1, 5'h0A, 1);
            checkOutput("contention_src", {31'b0, out_src}, ROUND_ROBIN ? (i % 2) : 0);
        end
        applyStimulus(0, 0, 5'h00, 0, 5'h00, 1);

        // Backpressure: hold 0x0A for three cycles, then drain and load at once.
        applyStimulus(0, 0, 5'h00, 1, 5'h0A, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 5'h00, 1, 5'h11, 0);
            checkOutput("stall_data", {27'b0, out_data}, 32'h0A);
        end
        applyStimulus(0, 0, 5'h00, 1, 5'h11, 1);
        checkOutput("reload_valid", {31'b0, out_valid}, 1);
        checkOutput("reload_data", {27'b0, out_data}, 32'h11);
        applyStimulus(0, 0, 5'h00, 0, 5'h00, 1);

        // Source 0 always requesting, source 1 every other cycle.
        grants0 = 0;
        w0 = 5'h01;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, w0, (i % 2) == 0, 5'h1F - 5'(i), 1);
            if (exp_ready0) begin
                grants0++;
                w0 = w0 + 5'h01;
            end
        end
        checkOutput("in0_not_starved", {31'b0, grants0 >= 4}, 1);
        applyStimulus(0, 0, 5'h00, 0, 5'h00, 1);

        // Reset while holding 0x15; first contention afterwards goes to source 0.
        applyStimulus(0, 1, 5'h15, 0, 5'h00, 0);
        applyStimulus(1, 1, 5'h15, 1, 5'h0A, 0);
        checkOutput("reset_drop_valid", {31'b0, out_valid}, 0);
        applyStimulus(0, 1, 5'h03, 1, 5'h0C, 1);
        checkOutput("post_reset_src", {31'b0, out_src}, 0);
        checkOutput("post_reset_data", {27'b0, out_data}, 32'h03);

        // Randomised traffic with occasional resets; sources hold until taken.
        p0 = 1'b0;
        p1 = 1'b0;
        w0 = '0;
        w1 = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1;
                w0 = WIDTH'($urandom);
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1;
                w1 = WIDTH'($urandom);
            end
            applyStimulus($urandom_range(0, 99) == 0, p0, w0, p1, w1,
                          $urandom_range(0, 3) != 0);
            if (exp_ready0) p0 = 1'b0;
            if (exp_ready1) p1 = 1'b0;
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule : tb_rr_arb2
